// File: rtl/seq_compare_ctrl.sv
// seq_compare_ctrl: compares two WIDTH-bit operands byte by byte (MSB first)
// through one shared external 8-bit magnitude-comparator slice.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready              request handshake; req_a, req_b, req_sign operands
//   cmp_x/cmp_y/cmp_sign             byte pair + sign control driven to the slice
//   cmp_equal/cmp_greater/cmp_less   combinational slice result
//   rsp_valid/rsp_ready              response handshake
//   rsp_equal/greater/less           verdict; rsp_cycles = slice cycles used
module seq_compare_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [WIDTH-1:0]               req_a,
   input  logic [WIDTH-1:0]               req_b,
   input  logic                           req_sign,
   output logic [7:0]                     cmp_x,
   output logic [7:0]                     cmp_y,
   output logic                           cmp_sign,
   input  logic                           cmp_equal,
   input  logic                           cmp_greater,
   input  logic                           cmp_less,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic                           rsp_equal,
   output logic                           rsp_greater,
   output logic                           rsp_less,
   output logic [$clog2(WIDTH/8):0]       rsp_cycles
);

   localparam int unsigned N  = WIDTH / 8;
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sign_q;
   logic [CW-1:0]    cnt;
   logic             found;     // an unequal byte has already been seen
   logic             gt_q;
   logic             lt_q;

   logic [IW-1:0]    idx_m1;
   logic [CW-1:0]    cnt_p1;
   logic             last;
   logic             fin_eq;
   logic             fin_gt;
   logic             fin_lt;

   assign idx_m1 = idx - IW'(1);
   assign cnt_p1 = cnt + CW'(1);
   // Leave COMPARE at the bottom byte, or on the first difference when exiting early
   assign last   = (idx == IW'(0)) || (EARLY_EXIT && !cmp_equal);
   // The first unequal byte decides; later bytes never overwrite it
   assign fin_eq = !found && cmp_equal;
   assign fin_gt = found ? gt_q : (!cmp_equal && cmp_greater);
   assign fin_lt = found ? lt_q : (!cmp_equal && cmp_less);

   // Controller state, operand capture, slice drive and registered response
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= IW'(N - 1);
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         cnt         <= '0;
         found       <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_equal   <= 1'b0;
         rsp_greater <= 1'b0;
         rsp_less    <= 1'b0;
         rsp_cycles  <= '0;
         cmp_x       <= '0;
         cmp_y       <= '0;
         cmp_sign    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= COMPARE;
                  a_q       <= req_a;
                  b_q       <= req_b;
                  sign_q    <= req_sign;
                  idx       <= IW'(N - 1);
                  cnt       <= '0;
                  found     <= 1'b0;
                  req_ready <= 1'b0;
                  // Slice sees the top byte in the first COMPARE cycle
                  cmp_x     <= req_a[WIDTH-1 -: 8];
                  cmp_y     <= req_b[WIDTH-1 -: 8];
                  cmp_sign  <= req_sign;
               end
            end
            COMPARE: begin
               cnt <= cnt_p1;
               if (!cmp_equal && !found) begin
                  found <= 1'b1;
                  gt_q  <= cmp_greater;
                  lt_q  <= cmp_less;
               end
               if (last) begin
                  state       <= DONE;
                  rsp_valid   <= 1'b1;
                  rsp_equal   <= fin_eq;
                  rsp_greater <= fin_gt;
                  rsp_less    <= fin_lt;
                  rsp_cycles  <= cnt_p1;
                  cmp_x       <= '0;
                  cmp_y       <= '0;
                  cmp_sign    <= 1'b0;
               end else begin
                  idx      <= idx_m1;
                  // Only the top byte carries the sign; lower bytes are unsigned
                  cmp_x    <= a_q[8*int'(idx_m1) +: 8];
                  cmp_y    <= b_q[8*int'(idx_m1) +: 8];
                  cmp_sign <= 1'b0;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_compare_ctrl.sv
// Testbench for seq_compare_ctrl: two instances (EARLY_EXIT=1 and =0), each
// with its own behavioural 8-bit comparator slice, checked against a
// whole-operand compare model.
module tb_seq_compare_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_sign;
   logic        rsp_ready;
   logic        rsp_valid [2];
   logic        rsp_equal [2];
   logic        rsp_greater [2];
   logic        rsp_less [2];
   logic [2:0]  rsp_cycles [2];
   logic [7:0]  cmp_x_o [2];
   logic [7:0]  cmp_y_o [2];
   logic        cmp_sign_o [2];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] cx;
      logic [7:0] cy;
      logic       cs;
      logic       ce;
      logic       cg;
      logic       cl;

      assign ce = (cx == cy);
      assign cg = cs ? ($signed(cx) > $signed(cy)) : (cx > cy);
      assign cl = cs ? ($signed(cx) < $signed(cy)) : (cx < cy);
      assign cmp_x_o[g]    = cx;
      assign cmp_y_o[g]    = cy;
      assign cmp_sign_o[g] = cs;

      seq_compare_ctrl #(.WIDTH(32), .EARLY_EXIT(g == 0)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .req_valid   (req_valid[g]),
         .req_ready   (req_ready[g]),
         .req_a       (req_a),
         .req_b       (req_b),
         .req_sign    (req_sign),
         .cmp_x       (cx),
         .cmp_y       (cy),
         .cmp_sign    (cs),
         .cmp_equal   (ce),
         .cmp_greater (cg),
         .cmp_less    (cl),
         .rsp_valid   (rsp_valid[g]),
         .rsp_ready   (rsp_ready),
         .rsp_equal   (rsp_equal[g]),
         .rsp_greater (rsp_greater[g]),
         .rsp_less    (rsp_less[g]),
         .rsp_cycles  (rsp_cycles[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Reference: {greater, less} of the full operands
   function automatic logic [1:0] exp_rel(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (s) begin
         if ($signed(a) > $signed(b)) return 2'b10;
         if ($signed(a) < $signed(b)) return 2'b01;
      end else begin
         if (a > b) return 2'b10;
         if (a < b) return 2'b01;
      end
      return 2'b00;
   endfunction

   // Reference: number of slice cycles
   function automatic int exp_k(input logic [31:0] a, input logic [31:0] b, input bit early);
      if (!early) return 4;
      for (int i = 3; i >= 0; i--)
         if (((a >> (8*i)) & 32'hFF) != ((b >> (8*i)) & 32'hFF)) return 4 - i;
      return 4;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transaction on instance d; bp = cycles of rsp_ready backpressure
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input bit hold, input int bp);
      int         lat;
      int         k;
      logic [1:0] rel;
      rel = exp_rel(a, b, s);
      k   = exp_k(a, b, d == 0);
      rsp_ready = (bp == 0);
      lat = 0;
      while (!req_ready[d] && lat < 20) begin step(); lat++; end
      chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
      req_a = a; req_b = b; req_sign = s; req_valid[d] = 1'b1;
      step();
      if (!hold) req_valid[d] = 1'b0;
      req_a = $urandom; req_b = $urandom; req_sign = 1'($urandom_range(0, 1));
      chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      lat = 0;
      while (!rsp_valid[d] && lat < 40) begin step(); lat++; end
      chk("latency", 32'(lat), 32'(k));
      chk("rsp_equal", 32'(rsp_equal[d]), 32'(rel == 2'b00));
      chk("rsp_greater", 32'(rsp_greater[d]), 32'(rel[1]));
      chk("rsp_less", 32'(rsp_less[d]), 32'(rel[0]));
      chk("rsp_cycles", 32'(rsp_cycles[d]), 32'(k));
      for (int i = 0; i < bp; i++) begin
         req_valid[d] = (i == 2);
         step();
         chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
         chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
         chk("bp_result", 32'({rsp_greater[d], rsp_less[d], rsp_equal[d]}),
             32'({rel, rel == 2'b00}));
         chk("bp_cycles", 32'(rsp_cycles[d]), 32'(k));
      end
      if (bp > 0) req_valid[d] = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("post_valid", 32'(rsp_valid[d]), 32'd0);
      chk("post_req_ready", 32'(req_ready[d]), 32'd1);
      chk("post_hold", 32'({rsp_greater[d], rsp_less[d], rsp_equal[d]}),
          32'({rel, rel == 2'b00}));
      if (bp > 0) begin
         step();
         chk("bp_not_captured", 32'(req_ready[d]), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int          j;
      int          seen;
      reset = 1'b1; req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      req_a = '0; req_b = '0; req_sign = 1'b0; rsp_ready = 1'b1;
      step(); step();
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
         chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("rst_rsp", 32'({rsp_equal[d], rsp_greater[d], rsp_less[d], rsp_cycles[d]}), 32'd0);
         chk("rst_cmp", 32'({cmp_x_o[d], cmp_y_o[d], cmp_sign_o[d]}), 32'd0);
      end
      reset = 1'b0;
      step();

      // Directed cases
      txn(0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 0);
      txn(0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
      txn(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 0);
      txn(0, 32'h12345678, 32'h12345679, 1'b1, 1'b0, 0);
      txn(1, 32'h01FF0000, 32'h00000001, 1'b0, 1'b0, 0);
      txn(1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 0);

      // Backpressure with an ignored request pulse, then a normal request
      txn(0, 32'hCAFE0000, 32'hCAFF0000, 1'b0, 1'b0, 6);
      txn(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0);
      txn(1, 32'h00000010, 32'h00000010, 1'b1, 1'b0, 6);

      // Reset during the second COMPARE cycle aborts with no response
      req_a = 32'hAAAA5555; req_b = 32'hAAAA5555; req_sign = 1'b0; req_valid[1] = 1'b1;
      step();
      req_valid[1] = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_req_ready", 32'(req_ready[1]), 32'd1);
      chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      chk("abort_rsp", 32'({rsp_equal[1], rsp_greater[1], rsp_less[1], rsp_cycles[1]}), 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin step(); if (rsp_valid[1]) seen++; end
      chk("abort_no_response", 32'(seen), 32'd0);

      // Randomized requests on both instances
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = a;
         j = $urandom_range(0, 4);
         if (j < 4) begin
            b = b ^ (32'($urandom_range(1, 255)) << (8*j));
            for (int i = 0; i < j; i++)
               b = (b & ~(32'hFF << (8*i))) | (32'($urandom_range(0, 255)) << (8*i));
         end
         txn(n % 2, a, b, 1'($urandom_range(0, 1)), 1'b0, 0);
      end

      // Back-to-back with req_valid held high
      for (int n = 0; n < 8; n++)
         txn(0, $urandom, $urandom ^ (32'($urandom_range(0, 1)) << 31),
             1'($urandom_range(0, 1)), 1'b1, 0);
      req_valid[0] = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_compare_ctrl.md
Name: seq_compare_ctrl

Overview:
- Multi-cycle controller that shares one 8-bit magnitude-comparator slice (equal/greater/less, sign input on the top slice) to compare WIDTH-bit operands byte by byte, most significant byte first.
- Used by the NovaEdge32 branch/SLT path when an area-reduced compare is configured: trades latency for a single 8-bit slice.
- Owns operand capture, byte sequencing, sign application, early termination and the valid/ready handshakes.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 16.
- EARLY_EXIT, 1, 1 = stop at the first unequal byte; 0 = always scan all bytes, keeping the first unequal byte's verdict.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  compare request present.
- req_ready  output  1  controller can accept a request.
- req_a  input  WIDTH  operand x.
- req_b  input  WIDTH  operand y.
- req_sign  input  1  1 = two's-complement compare, 0 = unsigned.
- cmp_x  output  8  byte of a driven to the external slice.
- cmp_y  output  8  byte of b driven to the external slice.
- cmp_sign  output  1  sign control to the slice.
- cmp_equal  input  1  slice result, combinational from cmp_x/cmp_y/cmp_sign.
- cmp_greater  input  1  slice result.
- cmp_less  input  1  slice result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_equal  output  1  a == b.
- rsp_greater  output  1  a > b.
- rsp_less  output  1  a < b.
- rsp_cycles  output  clog2(WIDTH/8)+1  number of slice cycles used.

Behaviour:
- States: IDLE, COMPARE, DONE. N = WIDTH/8. Byte index idx counts from N-1 down to 0.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_equal/greater/less=0, rsp_cycles=0, cmp_x=cmp_y=0, cmp_sign=0, idx=N-1. A reset mid-operation aborts the compare with no response; the captured operands are don't-care.
- IDLE:
  - req_ready=1. On req_valid, capture a, b and sign into registers; go to COMPARE with idx=N-1 and cycle count=0.
  - cmp_x/cmp_y/cmp_sign are held at 0 in IDLE.
- COMPARE:
  - req_ready=0. cmp_x = a_q[8*idx+7:8*idx], cmp_y = b_q[...], cmp_sign = sign_q when idx==N-1, else 0. Lower bytes are always compared unsigned.
  - The slice result is sampled at the end of the same cycle; count increments every COMPARE cycle.
  - If !cmp_equal, the first time this occurs: latch greater/less and set equal=0.
  - EARLY_EXIT=1: go to DONE on the first unequal byte or at idx==0.
  - EARLY_EXIT=0: go to DONE only at idx==0; verdicts from later bytes do not overwrite the first one.
  - Otherwise decrement idx.
  - If all bytes are equal: rsp_equal=1, greater=less=0.
- DONE:
  - rsp_valid=1 with registered results and rsp_cycles stable.
  - Hold until rsp_ready=1, then go to IDLE. rsp_valid drops the next cycle and results keep their values.
  - No new request is accepted in the handshake cycle itself; req_ready rises on IDLE entry.
- Latency: request accepted at cycle T, COMPARE occupies T+1..T+k, rsp_valid is first high at T+k+1. k = index of first differing byte from the top plus 1 (EARLY_EXIT=1), else N.
- Exactly one of rsp_equal/greater/less is high whenever rsp_valid=1.
- req_valid outside IDLE is ignored (no capture, no error).
- Slice outputs are ignored outside COMPARE.
- Input operands may change after acceptance with no effect on the result.

Test Plan:
1. Bench instantiates the 8-bit comparator slice on the cmp_* ports. a=b=0x12345678, sign=0 -> rsp_equal=1, rsp_cycles=4, rsp_valid 5 cycles after acceptance.
2. a=0x80000000, b=0x7FFFFFFF, sign=1 -> rsp_less=1, rsp_cycles=1. Same operands with sign=0 -> rsp_greater=1, rsp_cycles=1.
3. a=0x12345678, b=0x12345679, sign=1 -> rsp_less=1, rsp_cycles=4. With EARLY_EXIT=0: a=0x01FF0000, b=0x00000001 -> rsp_greater=1, rsp_cycles=4.
4. Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid -> results and rsp_valid stable, req_ready=0. A second req_valid pulse in that window is not captured. Release -> IDLE, then the next request is processed correctly.
5. Assert reset in the 2nd COMPARE cycle -> the next cycle shows IDLE, req_ready=1, rsp_valid=0, all rsp_* = 0, and no response is ever produced for the aborted request.
6. Back-to-back: req_valid held high with new operands every acceptance, rsp_ready=1 -> one response per request in order, one IDLE cycle between responses.
